mult_unit: RTL



---
 rtl/mult_pkg.sv | 15 +
 rtl/mult_step.sv | 22 ++
 rtl/mult_unit.sv | 99 +++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared types and constants for the iterative unsigned multiplier.
package mult_pkg;

    localparam int MULT_W     = 32;
    localparam int PROD_W     = 64;
    localparam int STEP_CNT_W = 6;
    localparam logic [STEP_CNT_W-1:0] LAST_STEP = 6'd31;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_e;

endpackage

// File: rtl/mult_step.sv
// One radix-2 shift-add step: conditionally accumulate, then shift both operands.
module mult_step
    import mult_pkg::*;
#(
    parameter int W = MULT_W
) (
    input  logic [2*W-1:0] i_acc,
    input  logic [2*W-1:0] i_mcand,
    input  logic [W-1:0]   i_mplier,
    output logic [2*W-1:0] o_acc,
    output logic [2*W-1:0] o_mcand,
    output logic [W-1:0]   o_mplier,
    output logic           o_mplier_zero
);

    // The zero-extended multiplicand leaves room for all shifts, so this add never carries out.
    assign o_acc         = i_mplier[0] ? (i_acc + i_mcand) : i_acc;
    assign o_mcand       = i_mcand << 1;
    assign o_mplier      = i_mplier >> 1;
    assign o_mplier_zero = (i_mplier[W-1:1] == '0);

endmodule

// File: rtl/mult_unit.sv
// Multi-cycle unsigned WIDTH x WIDTH multiplier with busy/done handshake.
// Define MULT_UNIT_EARLY_TERM_EN to stop iterating once the remaining multiplier bits are zero.
module mult_unit
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int P_W = 2 * WIDTH;

    mult_state_e           r_state;
    logic [P_W-1:0]        r_acc;
    logic [P_W-1:0]        r_mcand;
    logic [WIDTH-1:0]      r_mplier;
    logic [STEP_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]      r_hi;
    logic [WIDTH-1:0]      r_lo;

    logic [P_W-1:0]        w_acc_nxt;
    logic [P_W-1:0]        w_mcand_nxt;
    logic [WIDTH-1:0]      w_mplier_nxt;
    logic                  w_mplier_zero;
    logic                  w_accept;
    logic                  w_last;

    mult_step #(.W(WIDTH)) u_step (
        .i_acc         (r_acc),
        .i_mcand       (r_mcand),
        .i_mplier      (r_mplier),
        .o_acc         (w_acc_nxt),
        .o_mcand       (w_mcand_nxt),
        .o_mplier      (w_mplier_nxt),
        .o_mplier_zero (w_mplier_zero)
    );

    // A start during RUN is dropped; IDLE and DONE both accept one.
    assign w_accept = start && (r_state != RUN);

`ifdef MULT_UNIT_EARLY_TERM_EN
    assign w_last = (r_cnt == LAST_STEP) || w_mplier_zero;
`else
    logic w_unused_zero;
    assign w_unused_zero = w_mplier_zero;
    assign w_last        = (r_cnt == LAST_STEP);
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            case (r_state)
                RUN: begin
                    r_acc    <= w_acc_nxt;
                    r_mcand  <= w_mcand_nxt;
                    r_mplier <= w_mplier_nxt;
                    r_cnt    <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_state      <= DONE;
                        {r_hi, r_lo} <= w_acc_nxt;
                    end
                end
                IDLE, DONE: begin
                    if (w_accept) begin
                        r_state  <= RUN;
                        r_acc    <= '0;
                        r_mcand  <= {{WIDTH{1'b0}}, multiplicand};
                        r_mplier <= multiplier;
                        r_cnt    <= '0;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy = (r_state == RUN);
    assign done = (r_state == DONE);
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
